// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry registered bundle with valid/ready handshake,
// load-use hazard stall and branch flush.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        instr_valid_i,
  output logic        ready_o,
  input  logic        flush_i,
  input  logic        ex_ready_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic        rd_we_o,
  output logic [31:0] imm_o,
  output logic        is_load_o,
  output logic        illegal_o
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic [31:0] instr_q, pc_q;
  logic        valid_q;
  logic        hazard, take, legal_op, uses_rs1, uses_rs2, writes_rd;
  logic [6:0]  in_op;

  assign opcode_o  = instr_q[6:0];
  assign rd_o      = instr_q[11:7];
  assign funct3_o  = instr_q[14:12];
  assign rs1_o     = instr_q[19:15];
  assign rs2_o     = instr_q[24:20];
  assign funct7_o  = instr_q[31:25];
  assign pc_o      = pc_q;
  assign valid_o   = valid_q;
  assign is_load_o = (opcode_o == OP_LOAD);

  always_comb begin
    imm_o     = '0;
    legal_op  = 1'b1;
    writes_rd = 1'b0;
    unique case (opcode_o)
      OP_LOAD, OP_OPIMM, OP_JALR: begin
        imm_o     = {{20{instr_q[31]}}, instr_q[31:20]};
        writes_rd = 1'b1;
      end
      OP_SYSTEM: begin
        imm_o     = {{20{instr_q[31]}}, instr_q[31:20]};
        writes_rd = (funct3_o != 3'd0);
      end
      OP_STORE:  imm_o = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      OP_BRANCH: imm_o = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                          instr_q[30:25], instr_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC: begin
        imm_o     = {instr_q[31:12], 12'b0};
        writes_rd = 1'b1;
      end
      OP_JAL: begin
        imm_o     = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                     instr_q[20], instr_q[30:21], 1'b0};
        writes_rd = 1'b1;
      end
      OP_OP:     writes_rd = 1'b1;
      OP_MISC:   ;
      default:   legal_op = 1'b0;
    endcase
  end

  assign illegal_o = (instr_q[1:0] != 2'b11) || !legal_op ||
                     ((opcode_o == OP_OP) && (funct7_o != 7'h00) && (funct7_o != 7'h20));
  assign rd_we_o   = writes_rd && (rd_o != 5'd0) && !illegal_o;

  // Operand usage of the incoming (not yet decoded) word, for load-use detection
  assign in_op    = instr_i[6:0];
  assign uses_rs1 = !((in_op == OP_LUI) || (in_op == OP_AUIPC) || (in_op == OP_JAL));
  assign uses_rs2 = (in_op == OP_BRANCH) || (in_op == OP_STORE) || (in_op == OP_OP);
  assign hazard   = instr_valid_i && valid_q && is_load_o && (rd_o != 5'd0) &&
                    ((uses_rs1 && instr_i[19:15] == rd_o) ||
                     (uses_rs2 && instr_i[24:20] == rd_o));

  assign ready_o = (!valid_q || ex_ready_i) && !hazard;
  assign take    = instr_valid_i && ready_o && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP;
      pc_q    <= '0;
    end else begin
      if (flush_i)                    valid_q <= 1'b0;
      else if (take)                  valid_q <= 1'b1;
      else if (valid_q && ex_ready_i) valid_q <= 1'b0;
      // Bundle only moves on an accepted transfer, so it is frozen while stalled
      if (take) begin
        instr_q <= instr_i;
        pc_q    <= pc_i;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random traffic, all checked
// every cycle against an arithmetic reference decoder and transfer model.
module tb_decode_stage;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic [31:0] instr_i = '0, pc_i = '0;
  logic        instr_valid_i = 1'b0, flush_i = 1'b0, ex_ready_i = 1'b0;
  logic        ready_o, valid_o, rd_we_o, is_load_o, illegal_o;
  logic [31:0] pc_o, imm_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [2:0]  funct3_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;

  int checks = 0, errors = 0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .pc_i(pc_i),
    .instr_valid_i(instr_valid_i), .ready_o(ready_o), .flush_i(flush_i),
    .ex_ready_i(ex_ready_i), .valid_o(valid_o), .pc_o(pc_o),
    .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .rd_we_o(rd_we_o),
    .imm_o(imm_o), .is_load_o(is_load_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6f, JALR = 7'h67,
    BRANCH = 7'h63, LOAD = 7'h03, STORE = 7'h23, OPIMM = 7'h13, OP = 7'h33,
    MISC = 7'h0f, SYSTEM = 7'h73;

  typedef struct packed {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    logic [4:0] rs1, rs2, rd; logic we; logic [31:0] imm; logic ld, ill;
  } dec_t;

  // Model state: what execute should currently see
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = 32'h13, m_pc = '0;

  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t d;
    logic [31:0] s;
    d.op = w[6:0]; d.f3 = w[14:12]; d.f7 = w[31:25];
    d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7];
    d.ld  = (d.op == LOAD);
    d.ill = (w[1:0] != 2'b11) ||
            !(d.op inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, MISC, SYSTEM}) ||
            (d.op == OP && !(d.f7 inside {7'h00, 7'h20}));
    s = {31'd0, w[31]};
    // Immediates as weighted field sums minus the sign bit's weight (mod 2^32)
    case (d.op)
      LOAD, OPIMM, JALR, SYSTEM: d.imm = 32'(w[30:20]) - s * 2048;
      STORE:       d.imm = 32'(w[30:25]) * 32 + 32'(w[11:7]) - s * 2048;
      BRANCH:      d.imm = 32'(w[7]) * 2048 + 32'(w[30:25]) * 32 + 32'(w[11:8]) * 2 - s * 4096;
      LUI, AUIPC:  d.imm = w & 32'hFFFF_F000;
      JAL:         d.imm = 32'(w[19:12]) * 4096 + 32'(w[20]) * 2048 + 32'(w[30:21]) * 2 - s * 1048576;
      default:     d.imm = 32'd0;
    endcase
    d.we = ((d.op inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP}) || (d.op == SYSTEM && d.f3 != 0))
           && d.rd != 0 && !d.ill;
    return d;
  endfunction

  function automatic logic exp_ready();
    dec_t h, n;
    logic hz;
    h  = ref_dec(m_instr);
    n  = ref_dec(instr_i);
    hz = instr_valid_i && m_valid && h.ld && h.rd != 0 &&
         ((!(n.op inside {LUI, AUIPC, JAL}) && n.rs1 == h.rd) ||
          ((n.op inside {BRANCH, STORE, OP}) && n.rs2 == h.rd));
    return (!m_valid || ex_ready_i) && !hz;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    dec_t e;
    e = ref_dec(m_instr);
    chk("ready",   32'(ready_o),   32'(exp_ready()));
    chk("valid",   32'(valid_o),   32'(m_valid));
    chk("pc",      pc_o,           m_pc);
    chk("opcode",  32'(opcode_o),  32'(e.op));
    chk("funct3",  32'(funct3_o),  32'(e.f3));
    chk("funct7",  32'(funct7_o),  32'(e.f7));
    chk("rs1",     32'(rs1_o),     32'(e.rs1));
    chk("rs2",     32'(rs2_o),     32'(e.rs2));
    chk("rd",      32'(rd_o),      32'(e.rd));
    chk("rd_we",   32'(rd_we_o),   32'(e.we));
    chk("imm",     imm_o,          e.imm);
    chk("is_load", 32'(is_load_o), 32'(e.ld));
    chk("illegal", 32'(illegal_o), 32'(e.ill));
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic er, input logic fl);
    @(negedge clk);
    instr_valid_i = v; instr_i = ins; pc_i = pc; ex_ready_i = er; flush_i = fl;
    #1;
    check_model();
  endtask

  task automatic tick();
    logic r;
    @(posedge clk);
    r = exp_ready();
    if (flush_i) m_valid = 1'b0;
    else if (instr_valid_i && r) begin
      m_valid = 1'b1; m_instr = instr_i; m_pc = pc_i;
    end else if (m_valid && ex_ready_i) m_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [11];
    ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, MISC, SYSTEM};
    w = $urandom;
    if ($urandom_range(0, 9) == 0) return w;
    w[6:0]   = ($urandom_range(0, 2) == 0) ? LOAD : ops[$urandom_range(0, 10)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    if (w[6:0] == OP && $urandom_range(0, 3) != 0)
      w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    #10;
    check_model();
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_imm", imm_o, 0);
    @(negedge clk); rst_n = 1'b1;

    // addi x1,x0,5
    drive(1, 32'h0050_0093, 32'h100, 1, 0);
    chk("rdy_after_rst", 32'(ready_o), 1);
    tick();
    drive(0, 0, 0, 1, 0);
    chk("addi_valid", 32'(valid_o), 1); chk("addi_rd", 32'(rd_o), 1);
    chk("addi_we", 32'(rd_we_o), 1);    chk("addi_imm", imm_o, 5);
    chk("addi_pc", pc_o, 32'h100);
    tick();

    // lw x5,0(x2) ; add x6,x5,x1 -> one bubble
    drive(1, 32'h0001_2283, 32'h110, 1, 0); tick();
    drive(1, 32'h0012_8333, 32'h114, 1, 0);
    chk("hz_ready", 32'(ready_o), 0); chk("hz_lw_valid", 32'(valid_o), 1);
    tick();
    drive(1, 32'h0012_8333, 32'h114, 1, 0);
    chk("hz_bubble", 32'(valid_o), 0); chk("hz_ready2", 32'(ready_o), 1);
    tick();
    drive(0, 0, 0, 1, 0);
    chk("hz_add_valid", 32'(valid_o), 1); chk("hz_add_rd", 32'(rd_o), 6);
    tick();

    // beq x0,x0,-4 ; sw x1,12(x2)
    drive(1, 32'hFE00_0EE3, 32'h200, 1, 0); tick();
    drive(1, 32'h0011_2623, 32'h204, 1, 0);
    chk("beq_imm", imm_o, 32'hFFFF_FFFC); chk("beq_we", 32'(rd_we_o), 0);
    tick();
    drive(0, 0, 0, 1, 0);
    chk("sw_imm", imm_o, 12);
    tick();

    // Backpressure for 3 cycles with a new instruction waiting
    drive(1, 32'h00A0_0113, 32'h300, 1, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0030_0193, 32'h304, 0, 0);
      chk("bp_ready", 32'(ready_o), 0); chk("bp_pc", pc_o, 32'h300);
      chk("bp_imm", imm_o, 10);
      tick();
    end
    drive(1, 32'h0030_0193, 32'h304, 1, 0);
    chk("bp_release", 32'(ready_o), 1);
    tick();
    drive(0, 0, 0, 1, 0);
    chk("bp_next_pc", pc_o, 32'h304); chk("bp_next_rd", 32'(rd_o), 3);
    tick();

    // Flush kills both held and incoming
    drive(1, 32'h0040_0213, 32'h400, 1, 0); tick();
    drive(1, 32'h0050_0293, 32'h404, 1, 1); tick();
    drive(0, 0, 0, 1, 0);
    chk("flush_valid", 32'(valid_o), 0); chk("flush_pc", pc_o, 32'h400);
    tick();

    // Illegal words still propagate
    drive(1, 32'h0000_0000, 32'h500, 1, 0); tick();
    drive(1, 32'hFFFF_FFFF, 32'h504, 1, 0);
    chk("ill0", 32'(illegal_o), 1); chk("ill0_we", 32'(rd_we_o), 0);
    chk("ill0_valid", 32'(valid_o), 1);
    tick();
    drive(1, 32'h0000_0013, 32'h508, 1, 0);
    chk("ill1", 32'(illegal_o), 1); chk("ill1_valid", 32'(valid_o), 1);
    tick();
    drive(0, 0, 0, 1, 0);
    chk("nop_we", 32'(rd_we_o), 0); chk("nop_ill", 32'(illegal_o), 0);
    tick();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      tick();
    end

    // Reset while an instruction is held
    drive(1, 32'h0001_2283, 32'h600, 0, 0); tick();
    @(negedge clk);
    instr_valid_i = 1'b0; flush_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_valid = 1'b0; m_instr = 32'h13; m_pc = '0;
    chk("midrst_valid", 32'(valid_o), 0); chk("midrst_pc", pc_o, 0);
    check_model();
    @(negedge clk); rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("postrst_ready", 32'(ready_o), 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The module SHALL have no parameters; all widths are 32 bits (RISCV_WORD_WIDTH, RISCV_ADDR_WIDTH).
REQ-002 Ports, in order:
  clk            in   1   clock; all state on posedge
  rst_n          in   1   reset, asynchronous, active-low
  instr_i        in   32  instruction word from fetch
  pc_i           in   32  address of instr_i
  instr_valid_i  in   1   instr_i/pc_i valid
  ready_o        out  1   decode accepts instr_i this cycle
  flush_i        in   1   kill held and incoming instruction (taken branch/jump)
  ex_ready_i     in   1   execute consumes the held instruction this cycle
  valid_o        out  1   decoded bundle valid
  pc_o           out  32  registered PC
  opcode_o       out  7   instr[6:0]
  funct3_o       out  3   instr[14:12]
  funct7_o       out  7   instr[31:25]
  rs1_o, rs2_o   out  5   source register indices
  rd_o           out  5   destination index
  rd_we_o        out  1   instruction writes rd (0 when rd==0)
  imm_o          out  32  sign-extended immediate
  is_load_o      out  1   opcode LOAD
  illegal_o      out  1   illegal instruction flag

Function
REQ-003 Input transfer SHALL occur when instr_valid_i && ready_o && !flush_i; the instruction is captured into the output register on that edge.
REQ-004 Output transfer SHALL occur when valid_o && ex_ready_i; all outputs except valid_o hold stable while valid_o && !ex_ready_i.
REQ-005 ready_o SHALL be (!valid_o || ex_ready_i) && !hazard; combinational, one-cycle pipeline latency, full throughput with no hazard.
REQ-006 hazard SHALL be: instr_valid_i && valid_o && is_load_o && rd_o!=0 && ((uses_rs1(instr_i) && instr_i[19:15]==rd_o) || (uses_rs2(instr_i) && instr_i[24:20]==rd_o)).
REQ-007 uses_rs1: all opcodes except LUI, AUIPC, JAL; uses_rs2: BRANCH, STORE, OP only.
REQ-008 When hazard && ex_ready_i, valid_o SHALL be 0 next cycle (one bubble); the instruction is accepted the following cycle.
REQ-009 Next valid_o: 0 if flush_i; else 1 on input transfer; else 0 on output transfer; else hold.
REQ-010 flush_i SHALL take priority over simultaneous input transfer, output transfer and hazard; the incoming instruction is discarded.
REQ-011 Immediates: I = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); U = {instr[31:12],12'b0}; J = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
REQ-012 Type select: LOAD/OP-IMM/JALR/SYSTEM->I, STORE->S, BRANCH->B, LUI/AUIPC->U, JAL->J, OP->imm_o=0.
REQ-013 rd_we_o SHALL be 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP and SYSTEM with funct3!=0, and only if rd!=0; 0 otherwise.
REQ-014 illegal_o SHALL be 1 if instr[1:0]!=2'b11, opcode not in RV32I set (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM), or OP with funct7 not 0x00/0x20; illegal instructions SHALL force rd_we_o=0 and still propagate with valid_o=1.
REQ-015 When valid_o=0 the bundle fields are don't-care to consumers but SHALL not toggle except on input transfer.

Reset
REQ-016 On rst_n low, asynchronously: valid_o=0, pc_o=0, instruction register=32'h0000_0013 (NOP), hence rd_we_o=0, illegal_o=0, is_load_o=0, imm_o=0.
REQ-017 ready_o SHALL be 1 in the first cycle after reset release; reset asserted mid-transfer discards the held instruction.

Verification
REQ-018 Stream addi x1,x0,5 (0x00500093) at pc 0x100, ex_ready_i=1 -> next cycle valid_o=1, rd_o=1, rd_we_o=1, imm_o=5, pc_o=0x100.
REQ-019 lw x5,0(x2) then add x6,x5,x1 back-to-back, ex_ready_i=1 -> ready_o=0 one cycle, one bubble (valid_o=0), add issued next.
REQ-020 Branch 0xFE000EE3 (beq x0,x0,-4) -> imm_o=0xFFFF_FFFC, rd_we_o=0; sw 0x00112623 -> imm_o=12.
REQ-021 valid_o=1, ex_ready_i=0 for 3 cycles with new instr_valid_i=1 -> outputs stable, ready_o=0, no loss; ex_ready_i=1 -> next instruction follows.
REQ-022 flush_i=1 with instr_valid_i=1 and valid_o=1 -> valid_o=0 next cycle, incoming instruction never appears.
REQ-023 instr 0x0000_0000 and 0xFFFF_FFFF -> illegal_o=1, rd_we_o=0, valid_o=1; addi x0,x0,0 -> rd_we_o=0, illegal_o=0.
